// File: rtl/sort_chk_pkg.sv
// Shared definitions for the sort result checker.
// Contents: FSM state encoding, order selectors, word size in bytes and
// a helper that sizes an index field so that it is never zero bits wide.
package sort_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int ORDER_ASC  = 0;
  localparam int ORDER_DESC = 1;

  localparam int WORD_BYTES = 4;

  // A single-element array still needs a 1-bit index register.
  function automatic int idx_width(input int n_elem);
    if (n_elem > 1) begin
      return $clog2(n_elem);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sort_result_checker_if.sv
// Data-memory read port used by the sort result checker.
// Ports (signals):
//   mem_rd_req  - read request, held until acknowledged
//   mem_rd_addr - byte address of the requested word
//   mem_rd_ack  - read complete; mem_rd_data valid in the same cycle
//   mem_rd_data - read data
// Modports: master (checker side), slave (memory side).
interface sort_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output mem_rd_req,
    output mem_rd_addr,
    input  mem_rd_ack,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req,
    input  mem_rd_addr,
    output mem_rd_ack,
    output mem_rd_data
  );

endinterface

// File: rtl/order_compare.sv
// Combinational order check between two neighbouring array elements.
// Ports:
//   prev - earlier element (index i-1)
//   cur  - later element (index i)
//   ok   - 1 when prev/cur satisfy the configured order relation
module order_compare
  import sort_chk_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ORDER      = 0,
  parameter int STRICT     = 1,
  parameter int SIGNED_CMP = 0
) (
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] cur,
  output logic              ok
);

  logic lt_s;
  logic eq_s;

  // Relation between prev and cur under the selected ordering rules.
  always_comb begin
    lt_s = 1'b0;
    eq_s = (prev == cur);
    ok   = 1'b0;
    if (SIGNED_CMP != 0) begin
      lt_s = ($signed(prev) < $signed(cur));
    end else begin
      lt_s = (prev < cur);
    end
    if (ORDER == ORDER_ASC) begin
      if (STRICT != 0) begin
        ok = lt_s;
      end else begin
        ok = lt_s | eq_s;
      end
    end else begin
      // Descending: mirrored relation, prev > cur (or >= when not strict).
      if (STRICT != 0) begin
        ok = ~lt_s & ~eq_s;
      end else begin
        ok = ~lt_s;
      end
    end
  end

endmodule

// File: rtl/sort_result_checker.sv
// Run monitor and array order self-check.
// Counts run cycles until the CPU PC reaches HALT_PC (or the cycle limit
// expires), then reads N_ELEM words from data memory and verifies their order.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - single-cycle pulse arming the checker (IDLE/DONE only)
//   pc           - CPU program counter, sampled only while running
//   mem          - data-memory read port (master side)
//   done         - result valid, held until the next start or reset
//   pass         - array found in the required order
//   timeout      - halt PC not seen within MAX_CYCLES
//   fail_index   - index i of the first violating pair (i-1, i)
//   cycle_count  - run cycles counted before the halt (saturating)
module sort_result_checker
  import sort_chk_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int HALT_PC    = 88,
  parameter int BASE_ADDR  = 512,
  parameter int N_ELEM     = 12,
  parameter int MAX_CYCLES = 100000,
  parameter int ORDER      = 0,
  parameter int STRICT     = 1,
  parameter int SIGNED_CMP = 0,
  localparam int IDX_W     = idx_width(N_ELEM),
  localparam int CNT_W     = $clog2(MAX_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         pc,
  sort_result_checker_if.master     mem,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [IDX_W-1:0]          fail_index,
  output logic [CNT_W-1:0]          cycle_count
);

  localparam logic [ADDR_W-1:0] HALT_PC_V  = ADDR_W'(HALT_PC);
  localparam logic [ADDR_W-1:0] BASE_V     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0]  MAX_V      = CNT_W'(MAX_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX_V = IDX_W'(N_ELEM - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              arm_s;
  logic              order_ok_s;

  order_compare #(
    .DATA_W    (DATA_W),
    .ORDER     (ORDER),
    .STRICT    (STRICT),
    .SIGNED_CMP(SIGNED_CMP)
  ) u_order_compare (
    .prev(prev_q),
    .cur (mem.mem_rd_data),
    .ok  (order_ok_s)
  );

  // Next-state, counter, address and result logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    fidx_d    = fidx_q;
    addr_d    = addr_q;
    req_d     = req_q;
    arm_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          arm_s = 1'b1;
        end else begin
          req_d = 1'b0;
        end
      end

      RUN: begin
        // Halt is checked first so it wins over the cycle limit on the same edge.
        if (pc == HALT_PC_V) begin
          if (N_ELEM == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            idx_d   = '0;
            addr_d  = BASE_V;
          end
        end else if (cnt_q == MAX_V) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          // Counter stops at MAX_V because the branch above leaves RUN first.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REQ: begin
        if (mem.mem_rd_ack) begin
          if (idx_q == '0) begin
            prev_d = mem.mem_rd_data;
            idx_d  = idx_q + IDX_W'(1);
            addr_d = addr_q + STEP_V;
          end else if (!order_ok_s) begin
            state_d = DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            fidx_d  = idx_q;
          end else if (idx_q == LAST_IDX_V) begin
            state_d = DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            prev_d = mem.mem_rd_data;
            idx_d  = idx_q + IDX_W'(1);
            addr_d = addr_q + STEP_V;
          end
        end else begin
          req_d = 1'b1;
        end
      end

      DONE: begin
        if (start) begin
          arm_s = 1'b1;
        end else begin
          req_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Arming clears every result so the next run starts from a clean slate.
    if (arm_s) begin
      state_d   = RUN;
      idx_d     = '0;
      prev_d    = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
      fidx_d    = '0;
      addr_d    = '0;
      req_d     = 1'b0;
    end else begin
      arm_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      fidx_q    <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      fidx_q    <= fidx_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
    end
  end

  assign mem.mem_rd_req  = req_q;
  assign mem.mem_rd_addr = addr_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign fail_index      = fidx_q;
  assign cycle_count     = cnt_q;

endmodule

// File: doc/sort_result_checker.md
Name: sort_result_checker

Overview:
- Synthesizable run-monitor and self-check block for the pipelined CPU bench and FPGA bring-up.
- Counts cycles while the CPU runs and detects a configurable halt PC.
- After the halt, reads an N-element array from data memory through a req/ack read port and checks its order.
- Reports pass/fail, the index of the first violation, a timeout flag and the run cycle count.

Parameters:
- DATA_W, 32, element width in bits.
- ADDR_W, 32, PC and byte-address width.
- HALT_PC, 88, PC value that ends the run.
- BASE_ADDR, 512, byte address of element 0. Must be word aligned.
- N_ELEM, 12, number of elements. Must be at least 1.
- MAX_CYCLES, 100000, run cycles allowed before timeout.
- ORDER, 0, required order: 0 = ascending, 1 = descending.
- STRICT, 1, 1 = adjacent elements must differ, 0 = equal neighbours allowed.
- SIGNED_CMP, 0, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk, in, 1, system clock. All logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse that arms the checker.
- pc, in, ADDR_W, current CPU PC register value.
- mem_rd_req, out, 1, read request.
- mem_rd_addr, out, ADDR_W, byte address of the word being read.
- mem_rd_ack, in, 1, read complete. mem_rd_data is valid in the same cycle.
- mem_rd_data, in, DATA_W, read data.
- done, out, 1, result valid. Stays high until the next start or reset.
- pass, out, 1, array is in the required order.
- timeout, out, 1, halt PC not seen within MAX_CYCLES.
- fail_index, out, IDX_W = clog2(N_ELEM), index i of the first violating pair (i-1, i).
- cycle_count, out, CNT_W = clog2(MAX_CYCLES+1), run cycles counted before the halt.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. All outputs are 0, including mem_rd_addr, fail_index and cycle_count.
- States: IDLE, RUN, REQ, DONE.
- IDLE:
  - start moves to RUN.
  - Entering RUN clears cycle_count, done, pass, timeout and fail_index.
- RUN:
  - cycle_count increments each clock.
  - pc == HALT_PC sampled on edge k: cycle_count freezes and state goes to REQ.
  - mem_rd_req is high from cycle k+1, with element index 0.
  - If N_ELEM == 1: go directly to DONE with pass=1 and no read.
  - cycle_count reaches MAX_CYCLES with no halt: go to DONE with timeout=1, pass=0.
  - A halt and the limit on the same edge: the halt wins.
- REQ:
  - mem_rd_req = 1 and mem_rd_addr = BASE_ADDR + 4*idx.
  - Hold req and addr stable until mem_rd_ack. Ack in the first req cycle is legal.
  - On ack with idx == 0: store the data as prev and increment idx.
  - On ack with idx > 0: compare prev to data.
    - ORDER = 0 requires prev < data (STRICT = 1) or prev <= data (STRICT = 0).
    - ORDER = 1 uses the mirrored relation.
    - SIGNED_CMP selects the signed or unsigned relation.
  - Violation: fail_index = idx, go to DONE with pass=0. No further reads.
  - idx == N_ELEM-1 with no violation: go to DONE with pass=1.
  - Otherwise: prev = data and increment idx.
  - Req may stay high across consecutive elements. One read completes per ack. Back-to-back acks give 1 element per cycle.
- Timing:
  - done asserts on the edge after the final ack.
  - mem_rd_req is low in IDLE, RUN and DONE.
- DONE:
  - Outputs hold.
  - start re-arms: go to RUN and clear all results as above.
- start in RUN or REQ is ignored.
- mem_rd_ack outside REQ is ignored.
- cycle_count saturates and never wraps.
- pc is sampled only in RUN.

Decomposition:
- Shared package sort_chk_pkg:
  - state enum (IDLE, RUN, REQ, DONE);
  - ORDER_ASC/ORDER_DESC localparams;
  - word-size constant (4 bytes).
- Sub-module order_compare: combinational, parameterised by DATA_W, ORDER, STRICT and SIGNED_CMP. Inputs prev and cur, output ok.
- FSM, counters and address generation stay in the top module.

Test Plan:
- Array 0,11,22,...,121 at 512, pc reaches 88 at cycle 400, ack in the same cycle as req -> done=1, pass=1, cycle_count=400, exactly 12 reads at 512..556.
- Same array with elements 5 and 6 swapped -> pass=0, fail_index=6, done on the edge after the 7th ack, 7 reads only.
- pc never reaches 88, MAX_CYCLES=50 -> done=1, timeout=1, pass=0, cycle_count=50, no req.
- ack delayed 3 cycles per read -> req and addr stable while waiting, pass=1, done 1 cycle after the 12th ack.
- Array with elements 3 and 4 equal to 33: STRICT=1 -> pass=0, fail_index=4; STRICT=0 -> pass=1. Signed mode with -5 before 3 -> pass=1 with SIGNED_CMP=1 and pass=0 with SIGNED_CMP=0 (ascending).
- rst_n low during REQ at idx 4 -> all outputs 0 in the same cycle. Then start plus a halt -> full rescan from idx 0 and correct result. Descending 121..0 with ORDER=1 -> pass=1.
